// File: rtl/sdram_init_seq_if.sv
// Command/handshake bundle between the SDRAM init sequencer and its neighbours.
// master: sequencer side (drives pad commands and done_o, samples init_req_i).
// slave : controller/requester side (drives init_req_i, observes the rest).
interface sdram_init_seq_if #(
    parameter int unsigned BA_WIDTH = 2
);
    logic                init_req_i;
    logic                cke_o;
    logic                cs_n_o;
    logic                ras_n_o;
    logic                cas_n_o;
    logic                we_n_o;
    logic [BA_WIDTH-1:0] ba_o;
    logic [12:0]         a_o;
    logic                done_o;

    modport master (
        input  init_req_i,
        output cke_o, cs_n_o, ras_n_o, cas_n_o, we_n_o, ba_o, a_o, done_o
    );

    modport slave (
        output init_req_i,
        input  cke_o, cs_n_o, ras_n_o, cas_n_o, we_n_o, ba_o, a_o, done_o
    );
endinterface

// File: rtl/sdram_init_seq.sv
// SDRAM power-up / re-init command sequencer.
// Sequence: powerup wait -> PRECHARGE ALL -> REF_COUNT x AUTO REFRESH -> LOAD MODE
// REGISTER -> done. A init_req_i pulse while done re-runs it from PRECHARGE.
// Ports: sdram_clk (sole clock), sdram_rst_n (async active-low reset),
//        bus (master modport): init_req_i in; cke_o, cs_n_o, ras_n_o, cas_n_o,
//        we_n_o, ba_o, a_o, done_o out (all registered).
module sdram_init_seq #(
    parameter int unsigned CLK_FREQ_MHZ  = 100,
    parameter int unsigned POWERUP_DELAY = 200,
    parameter int unsigned BURST_LENGTH  = 8,
    parameter int unsigned BA_WIDTH      = 2,
    parameter int unsigned tCAC          = 2,
    parameter int unsigned tRP           = 2,
    parameter int unsigned tRC           = 7,
    parameter int unsigned tMRD          = 2,
    parameter int unsigned REF_COUNT     = 2
) (
    input  logic             sdram_clk,
    input  logic             sdram_rst_n,
    sdram_init_seq_if.master bus
);
    localparam int unsigned PWR_CYC  = CLK_FREQ_MHZ * POWERUP_DELAY;
    localparam int unsigned MAX_RPRC = (tRP > tRC) ? tRP : tRC;
    localparam int unsigned MAX_T    = (MAX_RPRC > tMRD) ? MAX_RPRC : tMRD;
    localparam int unsigned MAX_CYC  = (PWR_CYC > MAX_T) ? PWR_CYC : MAX_T;
    localparam int unsigned CNT_W    = $clog2(MAX_CYC + 1);
    localparam int unsigned REF_W    = $clog2(REF_COUNT + 1);

    // Wait states are entered one cycle after their command with the counter
    // cleared, so the last wait cycle holds count t-2.
    localparam int unsigned PWR_LAST = PWR_CYC - 1;
    localparam int unsigned RP_LAST  = (tRP  > 1) ? tRP  - 2 : 0;
    localparam int unsigned RC_LAST  = (tRC  > 1) ? tRC  - 2 : 0;
    localparam int unsigned MRD_LAST = (tMRD > 1) ? tMRD - 2 : 0;

    localparam logic [2:0] BL_CODE = (BURST_LENGTH == 1) ? 3'd0 :
                                     (BURST_LENGTH == 2) ? 3'd1 :
                                     (BURST_LENGTH == 4) ? 3'd2 :
                                     (BURST_LENGTH == 8) ? 3'd3 : 3'd7;
    localparam logic [12:0] MODE_REG = {6'd0, 3'(tCAC), 1'b0, BL_CODE};
    localparam logic [12:0] PRE_ADDR = 13'h0400;   // a[10]=1: all banks

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;
    localparam logic [3:0] CMD_DES = 4'b1111;

    if (!(BURST_LENGTH == 0 || BURST_LENGTH == 1 || BURST_LENGTH == 2 ||
          BURST_LENGTH == 4 || BURST_LENGTH == 8)) begin : g_bad_bl
        $error("sdram_init_seq: unsupported BURST_LENGTH %0d", BURST_LENGTH);
    end
    if (!(tCAC == 2 || tCAC == 3)) begin : g_bad_cl
        $error("sdram_init_seq: unsupported tCAC %0d", tCAC);
    end

    typedef enum logic [2:0] {
        ST_WAIT_PWR,
        ST_PRE,
        ST_WAIT_RP,
        ST_REF,
        ST_WAIT_RC,
        ST_LMR,
        ST_WAIT_MRD,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REF_W-1:0]    refs_q, refs_d;
    logic                cke_q, cke_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [BA_WIDTH-1:0] ba_q, ba_d;
    logic [12:0]         a_q, a_d;
    logic                done_q, done_d;
    logic                more_refs;

    assign more_refs = (refs_q < REF_W'(REF_COUNT));

    // Next state, shared wait counter, refresh tally and next registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        refs_d  = refs_q;
        unique case (state_q)
            ST_WAIT_PWR: if (cnt_q == CNT_W'(PWR_LAST)) state_d = ST_PRE;
            ST_PRE:      state_d = (tRP == 1) ? ST_REF : ST_WAIT_RP;
            ST_WAIT_RP:  if (cnt_q == CNT_W'(RP_LAST)) state_d = ST_REF;
            ST_REF: begin
                if (tRC == 1) state_d = more_refs ? ST_REF : ST_LMR;
                else          state_d = ST_WAIT_RC;
            end
            ST_WAIT_RC:  if (cnt_q == CNT_W'(RC_LAST)) state_d = more_refs ? ST_REF : ST_LMR;
            ST_LMR:      state_d = (tMRD == 1) ? ST_DONE : ST_WAIT_MRD;
            ST_WAIT_MRD: if (cnt_q == CNT_W'(MRD_LAST)) state_d = ST_DONE;
            ST_DONE: begin
                cnt_d = '0;
                if (bus.init_req_i) state_d = ST_PRE;
            end
            default:     state_d = ST_WAIT_PWR;
        endcase

        // REF->REF (tRC=1) is a fresh entry even though the state is unchanged.
        if (state_d != state_q || state_d == ST_REF) cnt_d = '0;
        if (state_d == ST_PRE) refs_d = '0;
        if (state_d == ST_REF) refs_d = refs_q + REF_W'(1);

        cke_d  = 1'b1;
        cmd_d  = CMD_NOP;
        ba_d   = '0;
        a_d    = '0;
        done_d = (state_d == ST_DONE);
        unique case (state_d)
            ST_PRE: begin cmd_d = CMD_PRE; a_d = PRE_ADDR; end
            ST_REF:       cmd_d = CMD_REF;
            ST_LMR: begin cmd_d = CMD_LMR; a_d = MODE_REG; end
            default:      cmd_d = CMD_NOP;
        endcase
    end

    // State and output registers.
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state_q <= ST_WAIT_PWR;
            cnt_q   <= '0;
            refs_q  <= '0;
            cke_q   <= 1'b0;
            cmd_q   <= CMD_DES;
            ba_q    <= '0;
            a_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            refs_q  <= refs_d;
            cke_q   <= cke_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            a_q     <= a_d;
            done_q  <= done_d;
        end
    end

    assign bus.cke_o   = cke_q;
    assign bus.cs_n_o  = cmd_q[3];
    assign bus.ras_n_o = cmd_q[2];
    assign bus.cas_n_o = cmd_q[1];
    assign bus.we_n_o  = cmd_q[0];
    assign bus.ba_o    = ba_q;
    assign bus.a_o     = a_q;
    assign bus.done_o  = done_q;
endmodule

// File: tb/tb_sdram_init_seq.sv
// Self-checking bench for sdram_init_seq: three configurations run side by side
// (A: default short powerup, B: BL=0/CL3/8 refreshes, C: all timings 1), with
// per-cycle command/done checks against a table of expected events.
module tb_sdram_init_seq;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] LMR = 4'b0000;
    localparam logic [3:0] DES = 4'b1111;

    logic sdram_clk   = 1'b0;
    logic sdram_rst_n = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    sdram_init_seq_if #(.BA_WIDTH(2)) if_a ();
    sdram_init_seq_if #(.BA_WIDTH(2)) if_b ();
    sdram_init_seq_if #(.BA_WIDTH(2)) if_c ();

    sdram_init_seq #(
        .CLK_FREQ_MHZ(1), .POWERUP_DELAY(10), .BURST_LENGTH(8), .BA_WIDTH(2),
        .tCAC(2), .tRP(2), .tRC(7), .tMRD(2), .REF_COUNT(2)
    ) dut_a (.sdram_clk(sdram_clk), .sdram_rst_n(sdram_rst_n), .bus(if_a.master));

    sdram_init_seq #(
        .CLK_FREQ_MHZ(1), .POWERUP_DELAY(10), .BURST_LENGTH(0), .BA_WIDTH(2),
        .tCAC(3), .tRP(2), .tRC(7), .tMRD(2), .REF_COUNT(8)
    ) dut_b (.sdram_clk(sdram_clk), .sdram_rst_n(sdram_rst_n), .bus(if_b.master));

    sdram_init_seq #(
        .CLK_FREQ_MHZ(1), .POWERUP_DELAY(1), .BURST_LENGTH(8), .BA_WIDTH(2),
        .tCAC(2), .tRP(1), .tRC(1), .tMRD(1), .REF_COUNT(2)
    ) dut_c (.sdram_clk(sdram_clk), .sdram_rst_n(sdram_rst_n), .bus(if_c.master));

    typedef struct packed {
        logic        cke;
        logic [3:0]  cmd;
        logic        done;
        logic [1:0]  ba;
        logic [12:0] a;
    } obs_t;

    obs_t obs [3];
    assign obs[0] = {if_a.cke_o, if_a.cs_n_o, if_a.ras_n_o, if_a.cas_n_o, if_a.we_n_o,
                     if_a.done_o, if_a.ba_o, if_a.a_o};
    assign obs[1] = {if_b.cke_o, if_b.cs_n_o, if_b.ras_n_o, if_b.cas_n_o, if_b.we_n_o,
                     if_b.done_o, if_b.ba_o, if_b.a_o};
    assign obs[2] = {if_c.cke_o, if_c.cs_n_o, if_c.ras_n_o, if_c.cas_n_o, if_c.we_n_o,
                     if_c.done_o, if_c.ba_o, if_c.a_o};

    // One vector: either an input pulse (req=1) or an expected command at a cycle.
    typedef struct {
        int          inst;
        int          cyc;
        bit          req;
        logic [3:0]  cmd;
        logic [12:0] a;
    } vec_t;

    vec_t vecs [$];
    int   checks   = 0;
    int   failures = 0;

    function automatic int tmrd_of(input int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic void add(input int inst, input int cyc, input bit req,
                                input logic [3:0] cmd, input logic [12:0] a);
        vec_t v;
        v.inst = inst; v.cyc = cyc; v.req = req; v.cmd = cmd; v.a = a;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int i, input int c,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", name, i, c, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v);
        case (i)
            0:       if_a.init_req_i = v;
            1:       if_b.init_req_i = v;
            default: if_c.init_req_i = v;
        endcase
    endtask

    task automatic chk_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_cke"},  i, 0, 32'(obs[i].cke),  32'(1'b0));
            chk({tag, "_cmd"},  i, 0, 32'(obs[i].cmd),  32'(DES));
            chk({tag, "_done"}, i, 0, 32'(obs[i].done), 32'(1'b0));
            chk({tag, "_a"},    i, 0, 32'(obs[i].a),    32'(13'h0));
            chk({tag, "_ba"},   i, 0, 32'(obs[i].ba),   32'(2'b00));
        end
    endtask

    // Steps ncyc cycles after reset release, checking all three instances.
    task automatic run_seq(input int ncyc);
        int          last_lmr [3];
        bit          dexp [3];
        logic [3:0]  ec;
        logic [12:0] ea;
        bit          rq;
        for (int i = 0; i < 3; i++) begin
            last_lmr[i] = -1000;
            dexp[i]     = 1'b0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge sdram_clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                ec = NOP; ea = '0; rq = 1'b0;
                foreach (vecs[k]) begin
                    if (vecs[k].inst == i && vecs[k].cyc == c) begin
                        if (vecs[k].req) rq = 1'b1;
                        else begin ec = vecs[k].cmd; ea = vecs[k].a; end
                    end
                end
                if (ec == PRE) dexp[i] = 1'b0;
                if (c == last_lmr[i] + tmrd_of(i)) dexp[i] = 1'b1;
                if (ec == LMR) last_lmr[i] = c;
                chk("cke",  i, c, 32'(obs[i].cke),  32'(1'b1));
                chk("cmd",  i, c, 32'(obs[i].cmd),  32'(ec));
                chk("done", i, c, 32'(obs[i].done), 32'(dexp[i]));
                if (ec == PRE) begin
                    chk("pre_a10", i, c, 32'(obs[i].a[10]), 32'(1'b1));
                end else if (ec == LMR) begin
                    chk("lmr_a",  i, c, 32'(obs[i].a),  32'(ea));
                    chk("lmr_ba", i, c, 32'(obs[i].ba), 32'(2'b00));
                end else if (dexp[i]) begin
                    chk("done_a",  i, c, 32'(obs[i].a),  32'(13'h0));
                    chk("done_ba", i, c, 32'(obs[i].ba), 32'(2'b00));
                end
                set_req(i, rq);
            end
        end
    endtask

    initial begin
        // A: base sequence, mid-sequence request ignored, re-init from DONE.
        add(0, 10, 0, PRE, 13'h400);
        add(0, 12, 0, REF, 13'h0);
        add(0, 15, 1, NOP, 13'h0);
        add(0, 19, 0, REF, 13'h0);
        add(0, 26, 0, LMR, 13'h023);
        add(0, 40, 1, NOP, 13'h0);
        add(0, 41, 0, PRE, 13'h400);
        add(0, 43, 0, REF, 13'h0);
        add(0, 50, 0, REF, 13'h0);
        add(0, 57, 0, LMR, 13'h023);
        // B: eight refreshes, 7 cycles apart.
        add(1, 10, 0, PRE, 13'h400);
        for (int k = 0; k < 8; k++) add(1, 12 + 7 * k, 0, REF, 13'h0);
        add(1, 68, 0, LMR, 13'h037);
        // C: back-to-back commands.
        add(2, 1, 0, PRE, 13'h400);
        add(2, 2, 0, REF, 13'h0);
        add(2, 3, 0, REF, 13'h0);
        add(2, 4, 0, LMR, 13'h023);

        if_a.init_req_i = 1'b0;
        if_b.init_req_i = 1'b0;
        if_c.init_req_i = 1'b0;

        // Reset held 5 cycles, outputs checked while in reset.
        sdram_rst_n = 1'b0;
        for (int r = 0; r < 5; r++) begin
            @(posedge sdram_clk);
            #1;
            chk_reset("hold");
        end
        @(negedge sdram_clk);
        sdram_rst_n = 1'b1;
        run_seq(80);

        // Reset asserted at cycle 20 aborts at once; sequence restarts in full.
        @(negedge sdram_clk);
        sdram_rst_n = 1'b0;
        repeat (2) @(posedge sdram_clk);
        @(negedge sdram_clk);
        sdram_rst_n = 1'b1;
        run_seq(20);
        sdram_rst_n = 1'b0;
        #1;
        chk_reset("abort");
        repeat (3) @(posedge sdram_clk);
        @(negedge sdram_clk);
        sdram_rst_n = 1'b1;
        run_seq(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
